// File: rtl/lcd_ci_if.sv
// lcd_ci_if -- custom-instruction bus plus LCD pin group for lcd_ci_ctrl.
//   CI side : clk_en, start, dataA (bit0 = RS), dataB (bits 7:0 = byte),
//             result (status word), done (one-cycle strobe)
//   LCD side: read_write, register_select, enable_op, data_out[7:0]
// slave  = controller view, master = processor / bench view.
interface lcd_ci_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] result;
  logic        done;
  logic        read_write;
  logic        register_select;
  logic        enable_op;
  logic [7:0]  data_out;

  modport slave (
    input  clk_en, start, dataA, dataB,
    output result, done, read_write, register_select, enable_op, data_out
  );

  modport master (
    output clk_en, start, dataA, dataB,
    input  result, done, read_write, register_select, enable_op, data_out
  );
endinterface

// File: rtl/lcd_ci_ctrl.sv
// lcd_ci_ctrl -- HD44780 write controller behind a custom-instruction port.
// One start writes one byte (command or data) with setup / enable pulse /
// hold timing, optionally as two 4-bit nibbles, then waits the execution
// time of the LCD before strobing done with a status word.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : lcd_ci_if.slave (CI handshake + LCD pins)
module lcd_ci_ctrl #(
  parameter int BUS_4BIT   = 0,
  parameter int SETUP_CYC  = 4,
  parameter int EN_CYC     = 25,
  parameter int HOLD_CYC   = 4,
  parameter int SHORT_WAIT = 2500,
  parameter int LONG_WAIT  = 100000,
  parameter int CNT_W      = 32
) (
  input  logic     clk,
  input  logic     reset,
  lcd_ci_if.slave  bus
);
  localparam bit IS4 = (BUS_4BIT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_ld;
  logic             r_rs, r_nib;
  logic [7:0]       r_byte;
  logic [31:0]      r_result;
  logic             w_cnt_z, w_long, w_unused;

  assign w_cnt_z  = (r_cnt == '0);
  // clear (0x01) and home (0x02/0x03) are the slow HD44780 commands
  assign w_long   = !r_rs && (r_byte[7:2] == 6'd0) && (r_byte != 8'd0);
  assign w_unused = ^{bus.dataA[31:1], bus.dataB[31:8]};

  // state register + timing counter; everything freezes while clk_en=0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (bus.clk_en) begin
      r_state <= w_nxt;
      // reload on every state change (incl. HOLD->SETUP for the 2nd nibble)
      if (w_nxt != r_state) r_cnt <= w_ld;
      else if (!w_cnt_z)    r_cnt <= r_cnt - 1'b1;
    end
  end

  // next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nxt = S_SETUP;
      S_SETUP: if (w_cnt_z)   w_nxt = S_PULSE;
      S_PULSE: if (w_cnt_z)   w_nxt = S_HOLD;
      S_HOLD:  if (w_cnt_z)   w_nxt = (IS4 && !r_nib) ? S_SETUP : S_WAIT;
      S_WAIT:  if (w_cnt_z)   w_nxt = S_DONE;
      S_DONE:                 w_nxt = S_IDLE;
      default:                w_nxt = S_IDLE;
    endcase
  end

  // counter load = length-1 of the state being entered
  always_comb begin
    case (w_nxt)
      S_SETUP: w_ld = CNT_W'(SETUP_CYC - 1);
      S_PULSE: w_ld = CNT_W'(EN_CYC - 1);
      S_HOLD:  w_ld = CNT_W'(HOLD_CYC - 1);
      S_WAIT:  w_ld = w_long ? CNT_W'(LONG_WAIT - 1) : CNT_W'(SHORT_WAIT - 1);
      default: w_ld = '0;
    endcase
  end

  // latched request, nibble flag and status word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs     <= 1'b0;
      r_byte   <= 8'd0;
      r_nib    <= 1'b0;
      r_result <= 32'd1;
    end else if (bus.clk_en) begin
      if (r_state == S_IDLE && bus.start) begin
        r_rs   <= bus.dataA[0];
        r_byte <= bus.dataB[7:0];
        r_nib  <= 1'b0;
      end
      if (r_state == S_HOLD && w_nxt == S_SETUP) r_nib <= 1'b1;
      // status is captured on entry to DONE so it is valid with the strobe
      if (r_state == S_WAIT && w_nxt == S_DONE)
        r_result <= {29'd0, IS4, w_long, 1'b0};
    end
  end

  // outputs: pure decode of registered state, so they hold with clk_en=0
  always_comb begin
    bus.done            = (r_state == S_DONE);
    bus.enable_op       = (r_state == S_PULSE);
    bus.register_select = r_rs;
    bus.data_out        = IS4 ? {(r_nib ? r_byte[3:0] : r_byte[7:4]), 4'h0} : r_byte;
    bus.read_write      = 1'b0;
    bus.result          = r_result;
  end
endmodule

// File: tb/tb_lcd_ci_ctrl.sv
// Bench for lcd_ci_ctrl: one 8-bit and one 4-bit instance, a table of
// directed transfers, hand sequences for gating / busy start / reset abort,
// then randomized transfers checked cycle-by-cycle against a timeline model.
module tb_lcd_ci_ctrl;
  localparam int S = 2, E = 3, H = 2, SW = 10, LW = 40;
  localparam int PASS = S + E + H;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0, n_err = 0;
  logic [31:0] prev_res [2];

  lcd_ci_if if8();
  lcd_ci_if if4();

  lcd_ci_ctrl #(.BUS_4BIT(0), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
                .SHORT_WAIT(SW), .LONG_WAIT(LW), .CNT_W(32))
    u8 (.clk(clk), .reset(rst_n), .bus(if8));
  lcd_ci_ctrl #(.BUS_4BIT(1), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
                .SHORT_WAIT(SW), .LONG_WAIT(LW), .CNT_W(32))
    u4 (.clk(clk), .reset(rst_n), .bus(if4));

  always #5 clk = ~clk;

  typedef struct {
    bit          m4;
    bit          rs;
    logic [7:0]  b;
    int          d;
    logic [31:0] res;
  } vec_t;

  // ---------------- reference model (timeline of one transfer) ----------
  function automatic bit m_long(input bit rs, input logic [7:0] b);
    return !rs && (b < 8'd4) && (b != 8'd0);
  endfunction

  function automatic int m_total(input bit m4, input bit rs, input logic [7:0] b);
    return 1 + PASS * (m4 ? 2 : 1) + (m_long(rs, b) ? LW : SW);
  endfunction

  function automatic logic [31:0] m_res(input bit m4, input bit rs, input logic [7:0] b);
    return {29'd0, m4, m_long(rs, b), 1'b0};
  endfunction

  // {rw, en, rs, done, data} after k enabled edges counted from start
  function automatic logic [11:0] m_out(input bit m4, input bit rs,
                                        input logic [7:0] b, input int k);
    int np, p, o;
    bit en;
    logic [7:0] d;
    np = m4 ? 2 : 1;
    p  = (k - 1) / PASS;
    if (p > np - 1) p = np - 1;
    o  = (k - 1) % PASS;
    en = (k <= PASS * np) && (o >= S) && (o < S + E);
    if (!m4)        d = b;
    else if (p == 0) d = {b[7:4], 4'h0};
    else             d = {b[3:0], 4'h0};
    return {1'b0, en, rs, (k == m_total(m4, rs, b)), d};
  endfunction

  // ---------------- helpers ---------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit m4, input bit ce, input bit st,
                       input logic [31:0] a, input logic [31:0] bb);
    if (m4) begin
      if4.clk_en = ce; if4.start = st; if4.dataA = a; if4.dataB = bb;
    end else begin
      if8.clk_en = ce; if8.start = st; if8.dataA = a; if8.dataB = bb;
    end
  endtask

  function automatic logic [11:0] get_out(input bit m4);
    if (m4) return {if4.read_write, if4.enable_op, if4.register_select, if4.done, if4.data_out};
    return {if8.read_write, if8.enable_op, if8.register_select, if8.done, if8.data_out};
  endfunction

  function automatic logic [31:0] get_res(input bit m4);
    return m4 ? if4.result : if8.result;
  endfunction

  // One full transfer, compared every cycle against the model.
  task automatic run_txn(input bit m4, input bit rs, input logic [7:0] b,
                         input int exp_d, input logic [31:0] exp_res,
                         input bit rnd, input int gap_at, input int gap_len,
                         input bit poke_busy, input bit poke_done);
    int k, nabs, kd, gaps, dm;
    bit ce, st;
    logic [31:0] a, bb, rm;
    logic [11:0] o, mo;
    k = 0; nabs = 0; kd = -1; gaps = 0;
    dm = m_total(m4, rs, b);
    rm = m_res(m4, rs, b);
    @(posedge clk); #1;
    drive(m4, 1'b1, 1'b1, {31'd0, rs}, {24'd0, b});
    ce = 1'b1;
    while (kd < 0 && nabs < 400) begin
      @(posedge clk);
      nabs++;
      if (ce) k++;
      #1;
      ce = 1'b1; st = 1'b0; a = {31'd0, rs}; bb = {24'd0, b};
      if (rnd && $urandom_range(3) == 0) ce = 1'b0;
      if (k == gap_at && gaps < gap_len) begin ce = 1'b0; gaps++; end
      if (poke_busy && k == 1) begin st = 1'b1; a = {31'd0, ~rs}; bb = 32'hFF; end
      if (k == dm) begin
        ce = 1'b1;
        if (poke_done) begin st = 1'b1; a = {31'd0, ~rs}; bb = {24'd0, ~b}; end
      end
      drive(m4, ce, st, a, bb);
      @(negedge clk);
      o  = get_out(m4);
      mo = m_out(m4, rs, b, k);
      chk("pins", 32'(o), 32'(mo));
      chk("result", get_res(m4), (k >= dm) ? rm : prev_res[m4]);
      if (o[8]) kd = k;
    end
    if (kd < 0) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done expected done at k=%0d", exp_d);
    end else begin
      chk("done_k", 32'(kd), 32'(exp_d));
      chk("done_res", get_res(m4), exp_res);
      if (gap_len > 0) chk("done_abs", 32'(nabs), 32'(exp_d + gap_len));
      @(posedge clk); #1;
      drive(m4, 1'b1, 1'b0, {31'd0, rs}, {24'd0, b});
      @(negedge clk);
      o  = get_out(m4);
      mo = m_out(m4, rs, b, dm);
      chk("post_done", 32'(o[8]), 32'd0);
      chk("post_data", 32'(o[7:0]), 32'(mo[7:0]));
    end
    prev_res[m4] = rm;
  endtask

  // Start a transfer and stop after n enabled edges (for reset aborts).
  task automatic partial(input bit m4, input bit rs, input logic [7:0] b, input int n);
    logic [11:0] mo;
    @(posedge clk); #1;
    drive(m4, 1'b1, 1'b1, {31'd0, rs}, {24'd0, b});
    @(posedge clk); #1;
    drive(m4, 1'b1, 1'b0, {31'd0, rs}, {24'd0, b});
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    mo = m_out(m4, rs, b, n);
    chk("pre_abort", 32'(get_out(m4)), 32'(mo));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pins8", 32'(get_out(1'b0)), 32'd0);
    chk("abort_pins4", 32'(get_out(1'b1)), 32'd0);
    chk("abort_res",   get_res(m4), 32'd1);
    prev_res[0] = 32'd1; prev_res[1] = 32'd1;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  vec_t tv [10];

  initial begin
    bit m4, rs;
    logic [7:0] b;
    tv[0] = '{1'b0, 1'b1, 8'h41, 18, 32'h0};
    tv[1] = '{1'b0, 1'b0, 8'h01, 48, 32'h2};
    tv[2] = '{1'b0, 1'b0, 8'h02, 48, 32'h2};
    tv[3] = '{1'b0, 1'b0, 8'h03, 48, 32'h2};
    tv[4] = '{1'b0, 1'b0, 8'h04, 18, 32'h0};
    tv[5] = '{1'b0, 1'b0, 8'h00, 18, 32'h0};
    tv[6] = '{1'b0, 1'b1, 8'h01, 18, 32'h0};
    tv[7] = '{1'b1, 1'b1, 8'hA5, 25, 32'h4};
    tv[8] = '{1'b1, 1'b0, 8'h01, 55, 32'h6};
    tv[9] = '{1'b1, 1'b0, 8'h28, 25, 32'h4};

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #3;
    // reset state, with clk_en low
    chk("rst_pins8", 32'(get_out(1'b0)), 32'd0);
    chk("rst_pins4", 32'(get_out(1'b1)), 32'd0);
    chk("rst_res8",  get_res(1'b0), 32'd1);
    chk("rst_res4",  get_res(1'b1), 32'd1);
    prev_res[0] = 32'd1; prev_res[1] = 32'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tv[i])
      run_txn(tv[i].m4, tv[i].rs, tv[i].b, tv[i].d, tv[i].res, 1'b0, -1, 0, 1'b0, 1'b0);

    // clk_en low for 5 cycles while enable is high
    run_txn(1'b0, 1'b1, 8'h41, 18, 32'h0, 1'b0, 3, 5, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 8'hA5, 25, 32'h4, 1'b0, 4, 5, 1'b0, 1'b0);
    // start pulsed while busy, and start held through DONE
    run_txn(1'b0, 1'b1, 8'h41, 18, 32'h0, 1'b0, -1, 0, 1'b1, 1'b0);
    run_txn(1'b1, 1'b1, 8'h3C, 25, 32'h4, 1'b0, -1, 0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 8'h01, 48, 32'h2, 1'b0, -1, 0, 1'b0, 1'b1);

    // reset during WAIT (8-bit) and during PULSE (4-bit), then recover
    partial(1'b0, 1'b1, 8'h41, 10);
    run_txn(1'b0, 1'b1, 8'h41, 18, 32'h0, 1'b0, -1, 0, 1'b0, 1'b0);
    partial(1'b1, 1'b1, 8'hA5, 4);
    run_txn(1'b1, 1'b1, 8'hA5, 25, 32'h4, 1'b0, -1, 0, 1'b0, 1'b0);

    // randomized transfers with random clock-enable gaps
    for (int i = 0; i < 30; i++) begin
      m4 = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      b  = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom_range(255));
      run_txn(m4, rs, b, m_total(m4, rs, b), m_res(m4, rs, b), 1'b1, -1, 0,
              1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lcd_ci_ctrl.md
LCD_CI_CTRL -- requirements
Module: lcd_ci_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- BUS_4BIT, 0, 1 selects HD44780 4-bit nibble transfer; 0 selects 8-bit transfer.
- SETUP_CYC, 4, cycles that RS and data are stable before enable rises (minimum 1).
- EN_CYC, 25, cycles that enable is held high (minimum 1).
- HOLD_CYC, 4, cycles that data is held after enable falls (minimum 1).
- SHORT_WAIT, 2500, execution wait after an ordinary command or data write (minimum 1).
- LONG_WAIT, 100000, execution wait after a clear or home command (minimum 1).
- CNT_W, 32, counter width; it SHALL hold LONG_WAIT.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- clk_en, in, 1, custom-instruction clock enable; the FSM advances only when it is 1.
- start, in, 1, custom-instruction start.
- dataA, in, 32, bit 0 is RS (0 = command, 1 = data).
- dataB, in, 32, bits 7:0 are the byte to write.
- result, out, 32, status word.
- done, out, 1, one-cycle completion strobe.
- read_write, out, 1, LCD R/W; held at constant 0.
- register_select, out, 1, LCD RS.
- enable_op, out, 1, LCD E.
- data_out, out, 8, LCD DB7..DB0.

Function
REQ-003 SHALL implement the states IDLE, SETUP, PULSE, HOLD, WAIT and DONE.
REQ-004 In IDLE with clk_en=1 and start=1, the block SHALL:
- latch RS = dataA[0] and byte = dataB[7:0];
- clear the nibble flag;
- load the counter;
- go to SETUP.
REQ-005 When clk_en=0, the state, counter and all outputs SHALL hold their values.
REQ-006 In SETUP (SETUP_CYC cycles), enable_op=0 and register_select/data_out SHALL drive the latched values.
REQ-007 In PULSE (EN_CYC cycles), enable_op=1 and data SHALL be unchanged.
REQ-008 In HOLD (HOLD_CYC cycles), enable_op=0 and data SHALL be unchanged.
REQ-009 8-bit mode: data_out SHALL be the byte, and HOLD SHALL be followed by WAIT.
REQ-010 4-bit mode:
- The first pass SHALL drive data_out = {byte[7:4], 4'b0}.
- After HOLD, the nibble flag SHALL be set and the block SHALL return to SETUP.
- The second pass SHALL drive {byte[3:0], 4'b0}.
- After the second HOLD, the block SHALL go to WAIT.
REQ-011 The WAIT length SHALL be LONG_WAIT when RS=0, byte[7:2]=0 and byte≠0 (clear or home); otherwise it SHALL be SHORT_WAIT.
REQ-012 DONE SHALL last one enabled cycle:
- done=1 and result valid during that cycle;
- the next state SHALL be IDLE;
- done=0 in every other state.
REQ-013 result SHALL be:
- bit 0 = 0 (success);
- bit 1 = long wait used;
- bit 2 = BUS_4BIT;
- bits 31:3 = 0.
result SHALL hold its value until the next DONE.
REQ-014 Latency, counting only enabled cycles from the start cycle T0:
- 8-bit: done SHALL be asserted at T0+1+SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- 4-bit: done SHALL be asserted at T0+1+2·(SETUP_CYC+EN_CYC+HOLD_CYC)+wait.
REQ-015 start SHALL be ignored outside IDLE; the latched RS and byte SHALL not change until the next IDLE acceptance.
REQ-016 start=1 in the same cycle as DONE SHALL NOT be accepted; it is accepted only if still asserted in IDLE.
REQ-017 The counter SHALL load (N−1) on entry to each timed state and SHALL advance on reaching 0; it SHALL never wrap.
REQ-018 read_write SHALL be 0 at all times, including during reset.

Reset
REQ-019 Asserting reset (low) SHALL, asynchronously, regardless of clk_en:
- force state=IDLE and counter=0;
- force done=0, enable_op=0, register_select=0 and data_out=0;
- force result=1 (not-complete status).
REQ-020 Reset asserted mid-transfer SHALL abort the transfer; enable_op SHALL drop to 0 within the same cycle, with no DONE produced.
REQ-021 After reset deasserts, the block SHALL accept start on the first enabled IDLE cycle.

Verification
Bench parameters: SETUP_CYC=2, EN_CYC=3, HOLD_CYC=2, SHORT_WAIT=10, LONG_WAIT=40.

REQ-022 8-bit data write:
- Stimulus: dataA=1, dataB=0x41, clk_en=1.
- Required: register_select=1; data_out=0x41; enable_op high for exactly 3 cycles beginning 3 cycles after start; done at T0+18; result=0.

REQ-023 8-bit clear:
- Stimulus: dataA=0, dataB=0x01.
- Required: LONG_WAIT is used; done at T0+48; result=0x2.

REQ-024 4-bit data write:
- Stimulus: BUS_4BIT=1, dataA=1, dataB=0xA5.
- Required: two enable pulses, the first with data_out=0xA0 and the second with data_out=0x50; done at T0+25; result=0x4.

REQ-025 Clock-enable gating:
- Stimulus: clk_en=0 for 5 cycles during PULSE.
- Required: enable_op stays 1 and the done time shifts by exactly 5 cycles.

REQ-026 Reset mid-transfer:
- Stimulus: reset low during WAIT.
- Required: immediately done=0, enable_op=0 and result=1; a subsequent start then completes normally.

REQ-027 Start while busy:
- Stimulus: start pulsed during SETUP with dataB=0xFF.
- Required: it is ignored, and the original byte is still transferred.
